eight_bit_search_initiator: RTL

- Sequential initiator that drives an 8-bit comparator interface.
- Finds an unknown 8-bit value held by a responder using binary search.
- Each probe is issued on `guess` under a req/ack handshake. The responder (comparator plus secret register) answers with lesser/equal/greater for guess vs secret.
- Reports the located value, probe count and error status. Used to exercise comparator datapaths and as a threshold finder.

---
 rtl/eight_bit_search_initiator.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/eight_bit_search_initiator.sv
// eight_bit_search_initiator
//
// Purpose: binary-search initiator. It drives probe values to an external
// comparator/responder over a req/ack handshake and narrows a [low, high]
// window until the responder reports equality. It then reports the located
// value, the number of accepted probes, and whether the responder behaved
// consistently.
//
// Handshake: req is the valid and ack is the ready. A probe transfers on
// any rising edge where req=1 and ack=1. While req=1 and ack=0, guess is
// held stable. ack while req=0 is ignored. cmp_l/cmp_e/cmp_g are only
// looked at in the transfer cycle. req stays high across consecutive
// probes, so one probe per cycle is possible.
//
// Ports:
//   clk     in   system clock, all state on rising edge
//   rst_n   in   synchronous active-low reset
//   start   in   begin a search (sampled in IDLE or DONE only)
//   guess   out  probe value (operand a of guess-vs-secret compare)
//   req     out  probe valid
//   ack     in   responder has l/e/g for the current guess
//   cmp_l   in   guess <  secret
//   cmp_e   in   guess == secret
//   cmp_g   in   guess >  secret
//   busy    out  search in progress
//   done    out  search finished, held until next start or reset
//   found   out  with done: result is the secret
//   error   out  with done: protocol or consistency failure
//   result  out  located value when found, else 0
//   steps   out  probes accepted in the current/last search
//
// All outputs come straight from flops; there is no combinational path
// from ack/cmp_* to any output.

module eight_bit_search_initiator #(
    parameter int WIDTH     = 8,
    parameter int MAX_STEPS = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    output logic             req,
    input  logic             ack,
    input  logic             cmp_l,
    input  logic             cmp_e,
    input  logic             cmp_g,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       steps
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL   = '1;
    localparam logic [WIDTH-1:0] FIRST_MID = MAX_VAL >> 1;
    localparam logic [3:0]       STEP_LIM  = 4'(MAX_STEPS);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       steps_q, steps_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic             error_q, error_d;

    // Window update candidates for the current response.
    logic [WIDTH-1:0] low_upd, high_upd;
    logic [WIDTH:0]   mid_sum;
    logic             hit_end;
    logic             resp_onehot;
    logic [3:0]       steps_inc;

    always_comb begin
        low_upd  = low_q;
        high_upd = high_q;
        hit_end  = 1'b0;
        if (cmp_l) begin
            // A "less" answer at the top of the range cannot be satisfied.
            hit_end = (guess_q == MAX_VAL);
            low_upd = guess_q + 1'b1;
        end else if (cmp_g) begin
            hit_end  = (guess_q == '0);
            high_upd = guess_q - 1'b1;
        end
        // One extra bit so low+high never wraps.
        mid_sum     = {1'b0, low_upd} + {1'b0, high_upd};
        resp_onehot = ({cmp_l, cmp_e, cmp_g} == 3'b100) ||
                      ({cmp_l, cmp_e, cmp_g} == 3'b010) ||
                      ({cmp_l, cmp_e, cmp_g} == 3'b001);
        steps_inc   = steps_q + 4'd1;
    end

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        low_d    = low_q;
        high_d   = high_q;
        result_d = result_q;
        steps_d  = steps_q;
        req_d    = req_q;
        busy_d   = busy_q;
        done_d   = done_q;
        found_d  = found_q;
        error_d  = error_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_PROBE;
                    low_d    = '0;
                    high_d   = MAX_VAL;
                    guess_d  = FIRST_MID;
                    req_d    = 1'b1;
                    busy_d   = 1'b1;
                    steps_d  = 4'd0;
                    done_d   = 1'b0;
                    found_d  = 1'b0;
                    error_d  = 1'b0;
                    result_d = '0;
                end
            end

            ST_PROBE: begin
                if (ack) begin
                    steps_d = steps_inc;
                    if (!resp_onehot || (!cmp_e && (hit_end ||
                        (low_upd > high_upd) || (steps_inc >= STEP_LIM)))) begin
                        state_d  = ST_DONE;
                        req_d    = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        found_d  = 1'b0;
                        error_d  = 1'b1;
                        result_d = '0;
                    end else if (cmp_e) begin
                        state_d  = ST_DONE;
                        req_d    = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        found_d  = 1'b1;
                        error_d  = 1'b0;
                        result_d = guess_q;
                    end else begin
                        low_d   = low_upd;
                        high_d  = high_upd;
                        guess_d = mid_sum[WIDTH:1];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            guess_q  <= '0;
            low_q    <= '0;
            high_q   <= MAX_VAL;
            result_q <= '0;
            steps_q  <= 4'd0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            low_q    <= low_d;
            high_q   <= high_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            error_q  <= error_d;
        end
    end

    assign guess  = guess_q;
    assign req    = req_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign found  = found_q;
    assign error  = error_q;
    assign result = result_q;
    assign steps  = steps_q;

endmodule
